// File: rtl/shade_pkg.sv
// Shared types and the combinational Shading arithmetic (texel x Gouraud modulate, clamp)
// used by the shade arbiter and its round-robin grant unit.
package shade_pkg;

    localparam logic       SRC_A    = 1'b0;
    localparam logic       SRC_B    = 1'b1;
    localparam logic [8:0] GOUR_ONE = 9'd256;

    typedef enum logic {
        PTR_A = 1'b0,
        PTR_B = 1'b1
    } rr_ptr_t;

    // The tag travels beside this struct because its width is a module parameter
    typedef struct packed {
        logic [14:0] tex;
        logic        noTex;
        logic [26:0] gour;
    } shade_req_t;

    function automatic logic [7:0] shadeChannel(input logic [8:0] gour, input logic [4:0] tex,
                                                input logic noTex);
        logic [13:0] prod;
        logic [7:0]  res;
        prod = gour * tex;
        if (noTex) begin
            res = gour[7:0];
        end else if (prod[13:5] >= GOUR_ONE) begin
            res = 8'd255;
        end else begin
            res = prod[12:5];
        end
        return res;
    endfunction

    function automatic logic [23:0] shadePixel(input shade_req_t req);
        return {shadeChannel(req.gour[26:18], req.tex[14:10], req.noTex),
                shadeChannel(req.gour[17:9],  req.tex[9:5],   req.noTex),
                shadeChannel(req.gour[8:0],   req.tex[4:0],   req.noTex)};
    endfunction

endpackage

// File: rtl/shade_rr_arb.sv
// Two-way grant unit: round-robin (or fixed priority to A) with its pointer register.
// Grants are only issued while enable is high and never during a flush.
module shade_rr_arb
    import shade_pkg::*;
#(
    parameter bit PRIO_A = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic enable,
    input  logic aValid,
    input  logic bValid,
    output logic grantA,
    output logic grantB
);

    rr_ptr_t ptr_r;
    rr_ptr_t ptrNext_s;
    logic    grantA_s;
    logic    grantB_s;

    // Grant decision and next pointer value
    always_comb begin
        grantA_s  = 1'b0;
        grantB_s  = 1'b0;
        ptrNext_s = ptr_r;
        if (flush) begin
            ptrNext_s = PTR_A;
        end else if (enable) begin
            case ({aValid, bValid})
                2'b10: begin
                    grantA_s  = 1'b1;
                    ptrNext_s = PTR_B;
                end
                2'b01: begin
                    grantB_s  = 1'b1;
                    ptrNext_s = PTR_A;
                end
                2'b11: begin
                    if (PRIO_A || (ptr_r == PTR_A)) begin
                        grantA_s  = 1'b1;
                        ptrNext_s = PTR_B;
                    end else begin
                        grantB_s  = 1'b1;
                        ptrNext_s = PTR_A;
                    end
                end
                default: begin
                    ptrNext_s = ptr_r;
                end
            endcase
        end else begin
            ptrNext_s = ptr_r;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= PTR_A;
        end else begin
            ptr_r <= ptrNext_s;
        end
    end

    assign grantA = grantA_s;
    assign grantB = grantB_s;

endmodule

// File: rtl/shade_arbiter.sv
// Shares one Shading datapath between the polygon rasterizer (A) and the rect/sprite
// walker (B) through a 2-stage valid/ready pipeline: S0 = arbitration register, S1 = output.
module shade_arbiter
    import shade_pkg::*;
#(
    parameter int TAGW   = 16,
    parameter bit PRIO_A = 1'b0
) (
    input  logic            clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_a_valid,
    output logic            o_a_ready,
    input  logic [14:0]     i_a_tex,
    input  logic            i_a_noTex,
    input  logic [26:0]     i_a_gour,
    input  logic [TAGW-1:0] i_a_tag,
    input  logic            i_b_valid,
    output logic            o_b_ready,
    input  logic [14:0]     i_b_tex,
    input  logic            i_b_noTex,
    input  logic [26:0]     i_b_gour,
    input  logic [TAGW-1:0] i_b_tag,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [23:0]     o_rgb,
    output logic            o_src,
    output logic [TAGW-1:0] o_tag
);

    logic            s0Valid_r;
    shade_req_t      s0Req_r;
    logic            s0Src_r;
    logic [TAGW-1:0] s0Tag_r;
    logic            s1Valid_r;
    logic [23:0]     s1Rgb_r;
    logic            s1Src_r;
    logic [TAGW-1:0] s1Tag_r;

    logic            s1Adv_s;
    logic            s0Adv_s;
    logic            arbEn_s;
    logic            grantA_s;
    logic            grantB_s;
    shade_req_t      reqSel_s;
    logic            srcSel_s;
    logic [TAGW-1:0] tagSel_s;
    logic [23:0]     shadedRgb_s;

    assign s1Adv_s = !s1Valid_r || i_ready;
    assign s0Adv_s = !s0Valid_r || s1Adv_s;
    // Keeping reset out of the enable holds both readies low while i_rst is high
    assign arbEn_s = s0Adv_s && !i_rst;

    shade_rr_arb #(
        .PRIO_A(PRIO_A)
    ) uArb (
        .clk   (clk),
        .rst   (i_rst),
        .flush (i_flush),
        .enable(arbEn_s),
        .aValid(i_a_valid),
        .bValid(i_b_valid),
        .grantA(grantA_s),
        .grantB(grantB_s)
    );

    assign o_a_ready = grantA_s;
    assign o_b_ready = grantB_s;

    // Mux the granted requester into the S0 load path
    always_comb begin
        reqSel_s = '{tex: i_a_tex, noTex: i_a_noTex, gour: i_a_gour};
        srcSel_s = SRC_A;
        tagSel_s = i_a_tag;
        if (grantB_s) begin
            reqSel_s = '{tex: i_b_tex, noTex: i_b_noTex, gour: i_b_gour};
            srcSel_s = SRC_B;
            tagSel_s = i_b_tag;
        end else begin
            srcSel_s = SRC_A;
        end
    end

    assign shadedRgb_s = shadePixel(s0Req_r);

    // S0 arbitration register
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            s0Valid_r <= 1'b0;
            s0Req_r   <= '0;
            s0Src_r   <= 1'b0;
            s0Tag_r   <= '0;
        end else if (i_flush) begin
            s0Valid_r <= 1'b0;
        end else if (s0Adv_s) begin
            s0Valid_r <= grantA_s || grantB_s;
            if (grantA_s || grantB_s) begin
                s0Req_r <= reqSel_s;
                s0Src_r <= srcSel_s;
                s0Tag_r <= tagSel_s;
            end
        end
    end

    // S1 output register, holds its contents while stalled
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            s1Valid_r <= 1'b0;
            s1Rgb_r   <= 24'd0;
            s1Src_r   <= 1'b0;
            s1Tag_r   <= '0;
        end else if (i_flush) begin
            s1Valid_r <= 1'b0;
        end else if (s1Adv_s) begin
            s1Valid_r <= s0Valid_r;
            if (s0Valid_r) begin
                s1Rgb_r <= shadedRgb_s;
                s1Src_r <= s0Src_r;
                s1Tag_r <= s0Tag_r;
            end
        end
    end

    assign o_valid = s1Valid_r;
    assign o_rgb   = s1Rgb_r;
    assign o_src   = s1Src_r;
    assign o_tag   = s1Tag_r;

endmodule

// File: tb/tb_shade_arbiter.sv
// Randomized and directed bench for shade_arbiter against a behavioural pipeline model;
// a second instance with PRIO_A=1 shows B is starved while A stays valid.
module tb_shade_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        aValid = 1'b0, bValid = 1'b0, ready = 1'b1;
    logic [14:0] aTex = 15'd0, bTex = 15'd0;
    logic        aNoTex = 1'b0, bNoTex = 1'b0;
    logic [26:0] aGour = 27'd0, bGour = 27'd0;
    logic [15:0] aTag = 16'd0, bTag = 16'd0;
    logic        aReady, bReady, oValid, oSrc;
    logic [23:0] oRgb;
    logic [15:0] oTag;
    logic        pAReady, pBReady, pValid, pSrc;
    logic [23:0] pRgb;
    logic [15:0] pTag;

    int checkCount = 0;
    int passCount  = 0;
    int cntA = 0, cntB = 0;
    bit prioPhase = 1'b0;

    // Model: two pipeline slots plus round-robin pointer (0 = A next)
    bit          mS0v = 1'b0, mS1v = 1'b0;
    logic [23:0] mS0rgb = 24'd0, mS1rgb = 24'd0;
    bit          mS0src = 1'b0, mS1src = 1'b0;
    logic [15:0] mS0tag = 16'd0, mS1tag = 16'd0;
    int          mPtr = 0;

    always #5 clk = ~clk;

    shade_arbiter #(.TAGW(16), .PRIO_A(1'b0)) dut (
        .clk(clk), .i_rst(rst), .i_flush(flush),
        .i_a_valid(aValid), .o_a_ready(aReady), .i_a_tex(aTex), .i_a_noTex(aNoTex),
        .i_a_gour(aGour), .i_a_tag(aTag),
        .i_b_valid(bValid), .o_b_ready(bReady), .i_b_tex(bTex), .i_b_noTex(bNoTex),
        .i_b_gour(bGour), .i_b_tag(bTag),
        .o_valid(oValid), .i_ready(ready), .o_rgb(oRgb), .o_src(oSrc), .o_tag(oTag)
    );

    shade_arbiter #(.TAGW(16), .PRIO_A(1'b1)) dutPrio (
        .clk(clk), .i_rst(rst), .i_flush(flush),
        .i_a_valid(aValid), .o_a_ready(pAReady), .i_a_tex(aTex), .i_a_noTex(aNoTex),
        .i_a_gour(aGour), .i_a_tag(aTag),
        .i_b_valid(bValid), .o_b_ready(pBReady), .i_b_tex(bTex), .i_b_noTex(bNoTex),
        .i_b_gour(bGour), .i_b_tag(bTag),
        .o_valid(pValid), .i_ready(ready), .o_rgb(pRgb), .o_src(pSrc), .o_tag(pTag)
    );

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs === exp) passCount++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [23:0] refShade(input logic [14:0] tex, input logic noTex,
                                             input logic [26:0] gour);
        int res = 0;
        for (int c = 0; c < 3; c++) begin
            int g = int'((gour >> (9 * c)) & 27'd511);
            int t = int'((tex >> (5 * c)) & 15'd31);
            int v;
            if (noTex) v = g % 256;
            else begin
                v = (g * t) / 32;
                if (v > 255) v = 255;
            end
            res = res | (v << (8 * c));
        end
        return res[23:0];
    endfunction

    task automatic randPix();
        aTex = 15'($urandom); bTex = 15'($urandom);
        aGour = 27'($urandom); bGour = 27'($urandom);
        aNoTex = ($urandom_range(0, 7) == 0); bNoTex = ($urandom_range(0, 7) == 0);
        aTag = 16'($urandom); bTag = 16'($urandom);
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge
    task automatic step();
        bit adv1, adv0, en, gA, gB;
        #1;
        adv1 = !mS1v || ready;
        adv0 = !mS0v || adv1;
        en   = adv0 && !flush;
        gA   = en && aValid && (!bValid || mPtr == 0);
        gB   = en && bValid && !gA;
        checkEq("aReady", aReady, gA);
        checkEq("bReady", bReady, gB);
        checkEq("oValid", oValid, mS1v);
        if (mS1v) begin
            checkEq("oRgb", oRgb, mS1rgb);
            checkEq("oSrc", oSrc, mS1src);
            checkEq("oTag", oTag, mS1tag);
        end
        if (prioPhase) begin
            checkEq("prioAReady", pAReady, 32'd1);
            checkEq("prioBReady", pBReady, 32'd0);
            if (pValid) checkEq("prioSrc", pSrc, 32'd0);
        end
        if (oValid && ready && !flush) begin
            if (oSrc) cntB++; else cntA++;
        end
        @(posedge clk);
        if (flush) begin
            mS0v = 1'b0; mS1v = 1'b0; mPtr = 0;
        end else begin
            if (adv1) begin
                mS1v = mS0v;
                if (mS0v) begin mS1rgb = mS0rgb; mS1src = mS0src; mS1tag = mS0tag; end
            end
            if (adv0) begin
                mS0v = gA || gB;
                if (gA) begin mS0rgb = refShade(aTex, aNoTex, aGour); mS0src = 1'b0; mS0tag = aTag; end
                else if (gB) begin mS0rgb = refShade(bTex, bNoTex, bGour); mS0src = 1'b1; mS0tag = bTag; end
            end
            if (gA) mPtr = 1;
            else if (gB) mPtr = 0;
        end
        @(negedge clk);
    endtask

    task automatic modelReset();
        mS0v = 1'b0; mS1v = 1'b0; mPtr = 0;
    endtask

    initial begin
        // Reset state, with A requesting to show ready stays low
        aValid = 1'b1; bValid = 1'b1;
        #2;
        checkEq("rstValid", oValid, 32'd0);
        checkEq("rstRgb", oRgb, 32'd0);
        checkEq("rstSrc", oSrc, 32'd0);
        checkEq("rstTag", oTag, 32'd0);
        checkEq("rstAReady", aReady, 32'd0);
        checkEq("rstBReady", bReady, 32'd0);
        @(negedge clk);
        aValid = 1'b0; bValid = 1'b0;
        rst = 1'b0;

        // A only: tex r=16, gour r=128 -> 64
        aValid = 1'b1; aTex = 15'd16; aGour = 27'd128; aNoTex = 1'b0; aTag = 16'h1234;
        ready = 1'b1;
        step();
        aValid = 1'b0;
        step();
        #1;
        checkEq("aOnlyValid", oValid, 32'd1);
        checkEq("aOnlyR", oRgb[7:0], 32'd64);
        checkEq("aOnlySrc", oSrc, 32'd0);
        checkEq("aOnlyTag", oTag, 32'h1234);
        step();

        // Clamp / noTex: r 511*31 -> 255, g 256*31 -> 248, then noTex gour 300 -> 44
        aValid = 1'b1; aTex = {5'd0, 5'd31, 5'd31}; aGour = {9'd0, 9'd256, 9'd511};
        aNoTex = 1'b0; aTag = 16'h0001;
        step();
        aTex = 15'h7fff; aGour = {9'd0, 9'd0, 9'd300}; aNoTex = 1'b1; aTag = 16'h0002;
        step();
        aValid = 1'b0;
        #1;
        checkEq("clampR", oRgb[7:0], 32'd255);
        checkEq("clampG", oRgb[15:8], 32'd248);
        step();
        #1;
        checkEq("noTexR", oRgb[7:0], 32'd44);
        step();

        // Randomized traffic with backpressure and occasional flush
        for (int i = 0; i < 300; i++) begin
            randPix();
            aValid = $urandom_range(0, 1); bValid = $urandom_range(0, 1);
            ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 31) == 0);
            step();
        end
        flush = 1'b0;

        // Backpressure: fill, hold ready low 5 cycles, then drain
        aValid = 1'b1; bValid = 1'b1; ready = 1'b0;
        for (int i = 0; i < 7; i++) begin randPix(); step(); end
        aValid = 1'b0; bValid = 1'b0; ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // Flush with 2 in flight, then both valid -> A wins
        aValid = 1'b1; bValid = 1'b1; ready = 1'b0;
        randPix(); step(); randPix(); step();
        aValid = 1'b0; bValid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; aValid = 1'b1; bValid = 1'b1; ready = 1'b1; randPix();
        #1;
        checkEq("flushValid", oValid, 32'd0);
        checkEq("flushGrantA", aReady, 32'd1);
        step();
        aValid = 1'b0; bValid = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Async reset mid-stream with a full pipe
        aValid = 1'b1; bValid = 1'b1; ready = 1'b0;
        for (int i = 0; i < 3; i++) begin randPix(); step(); end
        #2 rst = 1'b1;
        aValid = 1'b0; bValid = 1'b0; flush = 1'b0;
        #1;
        checkEq("asyncRstValid", oValid, 32'd0);
        checkEq("asyncRstAReady", aReady, 32'd0);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        modelReset();
        @(negedge clk);

        // Alternation: both valid for 100 accepts, PRIO_A=1 instance starves B
        cntA = 0; cntB = 0;
        aValid = 1'b1; bValid = 1'b1; ready = 1'b1; prioPhase = 1'b1;
        for (int i = 0; i < 100; i++) begin randPix(); step(); end
        prioPhase = 1'b0;
        aValid = 1'b0; bValid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        checkEq("rrCountA", cntA, 32'd50);
        checkEq("rrCountB", cntB, 32'd50);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
